// File: rtl/instr_fetch_queue_pkg.sv
// rtl/instr_fetch_queue_pkg.sv - shared FSM states and default sizes for the instruction fetch queue
package instr_fetch_queue_pkg;

  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch circular buffer holding {address, byte} pairs
module fetch_fifo
  import instr_fetch_queue_pkg::*;
#(
  parameter int W     = AW_DEF + DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // a push into a full buffer is only legal when the head leaves in the same cycle
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // pointer/count/storage update; flush wins over push and pop, stale data left in place
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - fetch FSM, fetch pointer and memory port feeding the prefetch buffer
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          branch_valid,
  input  logic [AW-1:0] branch_target,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          instr_valid,
  output logic [DW-1:0] instr_data,
  output logic [AW-1:0] instr_pc,
  input  logic          instr_ready,
  output logic [AW-1:0] fetch_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state, state_nxt;
  logic [AW-1:0] fetch_pc_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic          mem_req_nxt;
  logic [CW-1:0] count;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW+DW-1:0] head;
  logic          pop, ack, discard, push, room;
  logic [CW:0]   occ;

  assign pop     = instr_valid & instr_ready;
  assign ack     = mem_ack & mem_req;
  // data is thrown away in the branch cycle and for the request orphaned by a branch
  assign discard = branch_valid | (state == DROP);
  assign push    = ack & ~discard & (~fifo_full | pop);
  assign occ     = {1'b0, count} - {{CW{1'b0}}, pop} + {{CW{1'b0}}, push};
  assign room    = occ < (CW+1)'(DEPTH);

  assign instr_valid = ~fifo_empty;
  assign instr_pc    = head[AW+DW-1:DW];
  assign instr_data  = head[DW-1:0];

  fetch_fifo #(.W(AW + DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (branch_valid),
    .wdata ({mem_addr, mem_rdata}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  // next-state and memory-port decisions; a branch overrides everything else
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    mem_addr_nxt = mem_addr;
    mem_req_nxt  = mem_req;
    if (branch_valid) begin
      fetch_pc_nxt = branch_target;
      if ((state == REQ || state == DROP) && !ack) begin
        state_nxt = DROP;
      end else begin
        state_nxt    = REQ;
        mem_req_nxt  = 1'b1;
        mem_addr_nxt = branch_target;
      end
    end else begin
      case (state)
        IDLE: begin
          if (room) begin
            state_nxt    = REQ;
            mem_req_nxt  = 1'b1;
            mem_addr_nxt = fetch_pc;
          end
        end
        REQ: begin
          if (ack) begin
            fetch_pc_nxt = fetch_pc + AW'(1);
            if (room) begin
              mem_addr_nxt = fetch_pc + AW'(1);
            end else begin
              state_nxt   = IDLE;
              mem_req_nxt = 1'b0;
            end
          end
        end
        DROP: begin
          if (ack) begin
            if (room) begin
              state_nxt    = REQ;
              mem_addr_nxt = fetch_pc;
            end else begin
              state_nxt   = IDLE;
              mem_req_nxt = 1'b0;
            end
          end
        end
        default: begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
        end
      endcase
    end
  end

  // state, fetch pointer and memory port registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= '0;
      mem_addr <= '0;
      mem_req  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      mem_addr <= mem_addr_nxt;
      mem_req  <= mem_req_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       branch_valid;
  logic [7:0] branch_target;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       instr_valid;
  logic [7:0] instr_data;
  logic [7:0] instr_pc;
  logic       instr_ready;
  logic [7:0] fetch_pc;

  instr_fetch_queue dut (
    .clk           (clk),
    .reset         (reset),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .fetch_pc      (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];
  logic [7:0] q [$];
  logic [7:0] want;
  bit         stale;
  bit         pend;
  logic [7:0] pend_addr;
  int         wait_left;
  int         n_acks;
  bit         last_req;
  logic [7:0] last_addr;
  int         n_checks;
  int         n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    want      = 8'h00;
    stale     = 1'b0;
    pend      = 1'b0;
    wait_left = 0;
  endtask

  // one clock: drive inputs at the falling edge, check against the model, then advance the model
  task automatic cycle(input bit rdy, input int wmax, input bit br, input logic [7:0] tgt);
    bit ack;
    bit pop;
    @(negedge clk);
    ack = 1'b0;
    if (mem_req && wmax >= 0) begin
      if (wait_left == 0) begin
        ack       = 1'b1;
        wait_left = int'($urandom_range(wmax, 0));
      end else begin
        wait_left--;
      end
    end
    instr_ready   = rdy;
    branch_valid  = br;
    branch_target = tgt;
    mem_ack       = mem_req ? ack : 1'($urandom);
    mem_rdata     = mem[mem_addr];
    last_req      = mem_req;
    last_addr     = mem_addr;
    if (ack) n_acks++;

    check("instr_valid", instr_valid, q.size() != 0);
    check("fetch_pc", fetch_pc, want);
    if (mem_req && !stale) begin
      check("mem_addr", mem_addr, want);
      check("room_on_req", q.size() < DEPTH, 1);
    end
    if (pend) begin
      check("hold_req", mem_req, 1);
      check("hold_addr", mem_addr, pend_addr);
    end
    pop = rdy && (q.size() != 0);
    if (pop) begin
      check("instr_pc", instr_pc, q[0]);
      check("instr_data", instr_data, mem[q[0]]);
    end

    pend      = mem_req && !ack;
    pend_addr = mem_addr;
    if (br) begin
      q.delete();
      want  = tgt;
      stale = mem_req && !ack;
    end else begin
      if (pop) void'(q.pop_front());
      if (ack) begin
        if (stale) begin
          stale = 1'b0;
        end else begin
          q.push_back(mem_addr);
          want = want + 8'h01;
        end
      end
    end
  endtask

  initial begin
    bit rdy;
    bit br;
    int wmax;
    logic [7:0] tgt;
    n_checks = 0;
    n_pass   = 0;
    n_acks   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    model_reset();
    reset         = 1'b0;
    branch_valid  = 1'b0;
    branch_target = 8'h00;
    mem_ack       = 1'b0;
    mem_rdata     = 8'h00;
    instr_ready   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_data", instr_data, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_fetch_pc", fetch_pc, 0);
    @(negedge clk);
    reset = 1'b1;

    // decoder stalled, zero-wait memory: exactly DEPTH requests then the port goes quiet
    repeat (10) cycle(1'b0, 0, 1'b0, 8'h00);
    check("stall_acks", n_acks, DEPTH);
    check("stall_req_off", last_req, 0);
    cycle(1'b1, 0, 1'b0, 8'h00);
    cycle(1'b0, 0, 1'b0, 8'h00);
    check("refill_req", last_req, 1);
    check("refill_addr", last_addr, 8'h04);

    // streaming, slow memory with a branch to 0x40 during a wait, then a wrap through 0xFF
    repeat (8) cycle(1'b1, 0, 1'b0, 8'h00);
    wait_left = 3;
    cycle(1'b1, 3, 1'b0, 8'h00);
    cycle(1'b1, 3, 1'b1, 8'h40);
    repeat (12) cycle(1'b1, 3, 1'b0, 8'h00);
    wait_left = 0;
    cycle(1'b1, 0, 1'b1, 8'hFE);
    repeat (8) cycle(1'b1, 0, 1'b0, 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      rdy  = ((i % 200) < 30) ? 1'b0 : (($urandom % 4) != 0);
      br   = ($urandom % 20) == 0;
      tgt  = (($urandom % 4) == 0) ? 8'hFE : 8'($urandom);
      wmax = (i < 1000) ? 3 : ((i < 1800) ? 0 : 1);
      cycle(rdy, wmax, br, tgt);
    end

    // asynchronous reset while a request is outstanding
    repeat (6) cycle(1'b1, -1, 1'b0, 8'h00);
    check("pre_rst_req", last_req, 1);
    @(negedge clk);
    mem_ack      = 1'b0;
    branch_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_mem_req", mem_req, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_fetch_pc", fetch_pc, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (20) cycle(1'b1, 0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
